// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage types and constants: the IF/DE payload and the canonical NOP.
package fetch_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_inc;
      logic [31:0] inst;
      logic        valid;
   } if_de_t;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-stage bundle: branch/hazard inputs, IMEM data, IF/DE outputs and perf counters.
interface fetch_redirect_unit_if #(
   parameter int unsigned CNT_W = 32
);
   logic             NextPcSrc;
   logic [31:0]      BrTarget_ex;
   logic             Stall;
   logic [31:0]      Inst_if;
   logic [31:0]      Pc_if;
   logic [31:0]      Pc_de;
   logic [31:0]      PcInc_de;
   logic [31:0]      Inst_de;
   logic             Valid_de;
   logic             Flush_ex;
   logic             MisalignTrap;
   logic [CNT_W-1:0] RedirectCnt;
   logic [CNT_W-1:0] StallCnt;

   modport master (
      output NextPcSrc, BrTarget_ex, Stall, Inst_if,
      input  Pc_if, Pc_de, PcInc_de, Inst_de, Valid_de, Flush_ex, MisalignTrap,
             RedirectCnt, StallCnt
   );

   modport slave (
      input  NextPcSrc, BrTarget_ex, Stall, Inst_if,
      output Pc_if, Pc_de, PcInc_de, Inst_de, Valid_de, Flush_ex, MisalignTrap,
             RedirectCnt, StallCnt
   );

endinterface

// File: rtl/fetch_redirect_unit_if_de_reg.sv
// Pipeline register with bubble > hold > load priority; bubble reuses the reset payload.
module if_de_reg
   import fetch_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   bubble,
   input  logic   hold,
   input  if_de_t d,
   output if_de_t q
);

   localparam if_de_t BUBBLE = '{pc: '0, pc_inc: '0, inst: NOP_INST, valid: 1'b0};

   if_de_t q_d, q_q;

   always_comb begin
      q_d = d;
      if (bubble) begin
         q_d = BUBBLE;
      end else if (hold) begin
         q_d = q_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= BUBBLE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: PC select with redirect/trap/stall priority, IF/DE register, perf counters.
module fetch_redirect_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
   parameter int unsigned CNT_W    = 32
) (
   input logic                clk,
   input logic                rst_n,
   fetch_redirect_unit_if.slave bus
);

   logic             redirect, misalign;
   logic [31:0]      pc_d, pc_q;
   logic             trap_q;
   logic [CNT_W-1:0] redirect_cnt_d, redirect_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   if_de_t           de_d, de_q;

   assign redirect = bus.NextPcSrc;
   assign misalign = redirect && (bus.BrTarget_ex[1:0] != 2'b00);

   always_comb begin
      pc_d = pc_q + PC_STEP;
      if (misalign) begin
         pc_d = TRAP_PC;
      end else if (redirect) begin
         pc_d = bus.BrTarget_ex;
      end else if (bus.Stall) begin
         pc_d = pc_q;
      end
   end

   // Saturating counters; a stall squashed by a redirect is not counted.
   always_comb begin
      redirect_cnt_d = redirect_cnt_q;
      stall_cnt_d    = stall_cnt_q;
      if (redirect && (redirect_cnt_q != '1)) begin
         redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      end
      if (bus.Stall && !redirect && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         trap_q         <= 1'b0;
         redirect_cnt_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         pc_q           <= pc_d;
         trap_q         <= misalign;
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign de_d = '{pc: pc_q, pc_inc: pc_q + PC_STEP, inst: bus.Inst_if, valid: 1'b1};

   if_de_reg u_if_de_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (redirect),
      .hold   (bus.Stall),
      .d      (de_d),
      .q      (de_q)
   );

   assign bus.Pc_if        = pc_q;
   assign bus.Pc_de        = de_q.pc;
   assign bus.PcInc_de     = de_q.pc_inc;
   assign bus.Inst_de      = de_q.inst;
   assign bus.Valid_de     = de_q.valid;
   assign bus.Flush_ex     = redirect;
   assign bus.MisalignTrap = trap_q;
   assign bus.RedirectCnt  = redirect_cnt_q;
   assign bus.StallCnt     = stall_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench: directed vector table, mid-cycle reset, random run vs behavioural model.
module tb_fetch_redirect_unit;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] TRAP = 32'h0000_0100;
   localparam logic [31:0] I1   = 32'h00A0_0093;
   localparam logic [31:0] I2   = 32'h0020_8133;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_redirect_unit_if #(.CNT_W(32)) bus ();
   fetch_redirect_unit_if #(.CNT_W(3))  bus3 ();

   fetch_redirect_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Narrow-counter instance fed the same stimulus to exercise saturation.
   fetch_redirect_unit #(.CNT_W(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3.slave)
   );

   assign bus3.NextPcSrc   = bus.NextPcSrc;
   assign bus3.BrTarget_ex = bus.BrTarget_ex;
   assign bus3.Stall       = bus.Stall;
   assign bus3.Inst_if     = bus.Inst_if;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: architectural state after each edge.
   logic [31:0] m_pc, m_pc_de, m_inst_de;
   logic        m_valid, m_trap;
   longint      m_rc, m_sc;

   task automatic model_reset();
      m_pc = 32'h0; m_pc_de = 32'h0; m_inst_de = NOP; m_valid = 1'b0; m_trap = 1'b0;
      m_rc = 0; m_sc = 0;
   endtask

   task automatic model_edge(input logic nps, input logic [31:0] tgt, input logic stall,
                             input logic [31:0] inst);
      m_trap = nps && (tgt % 4 != 0);
      if (nps) begin
         m_rc++;
         m_pc_de = 32'h0; m_inst_de = NOP; m_valid = 1'b0;
         m_pc = (tgt % 4 != 0) ? TRAP : tgt;
      end else if (stall) begin
         m_sc++;
      end else begin
         m_pc_de = m_pc; m_inst_de = inst; m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
      end
   endtask

   function automatic logic [31:0] sat3(input longint v);
      return (v > 7) ? 32'd7 : 32'(v);
   endfunction

   task automatic check_model(input string tag);
      logic [31:0] e_inc;
      e_inc = m_valid ? m_pc_de + 32'd4 : 32'h0;
      chk({tag, ".Pc_if"}, bus.Pc_if, m_pc);
      chk({tag, ".Pc_de"}, bus.Pc_de, m_pc_de);
      chk({tag, ".PcInc_de"}, bus.PcInc_de, e_inc);
      chk({tag, ".Inst_de"}, bus.Inst_de, m_inst_de);
      chk({tag, ".Valid_de"}, 32'(bus.Valid_de), 32'(m_valid));
      chk({tag, ".MisalignTrap"}, 32'(bus.MisalignTrap), 32'(m_trap));
      chk({tag, ".RedirectCnt"}, bus.RedirectCnt, 32'(m_rc));
      chk({tag, ".StallCnt"}, bus.StallCnt, 32'(m_sc));
      chk({tag, ".RedirectCnt3"}, 32'(bus3.RedirectCnt), sat3(m_rc));
      chk({tag, ".StallCnt3"}, 32'(bus3.StallCnt), sat3(m_sc));
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input logic nps, input logic [31:0] tgt, input logic stall,
                        input logic [31:0] inst);
      bus.NextPcSrc = nps; bus.BrTarget_ex = tgt; bus.Stall = stall; bus.Inst_if = inst;
      #1;
      chk("Flush_ex", 32'(bus.Flush_ex), 32'(nps));
      model_edge(nps, tgt, stall, inst);
      @(negedge clk);
   endtask

   typedef struct {
      logic        nps;
      logic [31:0] tgt;
      logic        stall;
      logic [31:0] inst;
      logic [31:0] e_pc;
      logic [31:0] e_pc_de;
      logic [31:0] e_inst;
      logic        e_valid;
      logic        e_trap;
      logic [31:0] e_rc;
      logic [31:0] e_sc;
   } vec_t;

   vec_t tbl[16];

   initial begin
      logic [31:0] e_inc;
      logic        nps, stall;
      logic [31:0] tgt;

      tbl[0]  = '{1'b0, 32'h0,        1'b0, I1, 32'h4,        32'h0,        I1,  1'b1, 1'b0, 0, 0};
      tbl[1]  = '{1'b0, 32'h0,        1'b0, I1, 32'h8,        32'h4,        I1,  1'b1, 1'b0, 0, 0};
      tbl[2]  = '{1'b0, 32'h0,        1'b1, I1, 32'h8,        32'h4,        I1,  1'b1, 1'b0, 0, 1};
      tbl[3]  = '{1'b0, 32'h0,        1'b1, I1, 32'h8,        32'h4,        I1,  1'b1, 1'b0, 0, 2};
      tbl[4]  = '{1'b0, 32'h0,        1'b0, I1, 32'hC,        32'h8,        I1,  1'b1, 1'b0, 0, 2};
      tbl[5]  = '{1'b0, 32'h0,        1'b0, I1, 32'h10,       32'hC,        I1,  1'b1, 1'b0, 0, 2};
      tbl[6]  = '{1'b1, 32'h40,       1'b0, I1, 32'h40,       32'h0,        NOP, 1'b0, 1'b0, 1, 2};
      tbl[7]  = '{1'b0, 32'h0,        1'b0, I2, 32'h44,       32'h40,       I2,  1'b1, 1'b0, 1, 2};
      tbl[8]  = '{1'b1, 32'h80,       1'b1, I1, 32'h80,       32'h0,        NOP, 1'b0, 1'b0, 2, 2};
      tbl[9]  = '{1'b1, 32'h42,       1'b0, I1, 32'h100,      32'h0,        NOP, 1'b0, 1'b1, 3, 2};
      tbl[10] = '{1'b0, 32'h0,        1'b0, I1, 32'h104,      32'h100,      I1,  1'b1, 1'b0, 3, 2};
      tbl[11] = '{1'b1, 32'hFFFFFFFC, 1'b0, I1, 32'hFFFFFFFC, 32'h0,        NOP, 1'b0, 1'b0, 4, 2};
      tbl[12] = '{1'b0, 32'h0,        1'b0, I2, 32'h0,        32'hFFFFFFFC, I2,  1'b1, 1'b0, 4, 2};
      tbl[13] = '{1'b1, 32'h200,      1'b0, I1, 32'h200,      32'h0,        NOP, 1'b0, 1'b0, 5, 2};
      tbl[14] = '{1'b1, 32'h300,      1'b0, I1, 32'h300,      32'h0,        NOP, 1'b0, 1'b0, 6, 2};
      tbl[15] = '{1'b0, 32'h0,        1'b1, I1, 32'h300,      32'h0,        NOP, 1'b0, 1'b0, 6, 3};

      bus.NextPcSrc = 1'b0; bus.BrTarget_ex = 32'h0; bus.Stall = 1'b0; bus.Inst_if = I1;
      model_reset();
      repeat (2) @(negedge clk);
      check_model("reset");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i].nps, tbl[i].tgt, tbl[i].stall, tbl[i].inst);
         e_inc = tbl[i].e_valid ? tbl[i].e_pc_de + 32'd4 : 32'h0;
         chk($sformatf("vec%0d.Pc_if", i), bus.Pc_if, tbl[i].e_pc);
         chk($sformatf("vec%0d.Pc_de", i), bus.Pc_de, tbl[i].e_pc_de);
         chk($sformatf("vec%0d.PcInc_de", i), bus.PcInc_de, e_inc);
         chk($sformatf("vec%0d.Inst_de", i), bus.Inst_de, tbl[i].e_inst);
         chk($sformatf("vec%0d.Valid_de", i), 32'(bus.Valid_de), 32'(tbl[i].e_valid));
         chk($sformatf("vec%0d.MisalignTrap", i), 32'(bus.MisalignTrap), 32'(tbl[i].e_trap));
         chk($sformatf("vec%0d.RedirectCnt", i), bus.RedirectCnt, tbl[i].e_rc);
         chk($sformatf("vec%0d.StallCnt", i), bus.StallCnt, tbl[i].e_sc);
      end

      // Asynchronous reset asserted between clock edges.
      apply(1'b1, 32'h80, 1'b0, I1);
      bus.NextPcSrc = 1'b0;
      #2;
      chk("midrst.pre_Pc_if", bus.Pc_if, 32'h80);
      rst_n = 1'b0;
      #1;
      chk("midrst.Pc_if", bus.Pc_if, 32'h0);
      chk("midrst.RedirectCnt", bus.RedirectCnt, 32'h0);
      chk("midrst.StallCnt", bus.StallCnt, 32'h0);
      chk("midrst.Valid_de", 32'(bus.Valid_de), 32'h0);
      chk("midrst.Inst_de", bus.Inst_de, NOP);
      @(negedge clk);
      model_reset();
      check_model("midrst_hold");
      rst_n = 1'b1;

      for (int n = 0; n < 400; n++) begin
         nps   = ($urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 3) == 0);
         tgt   = $urandom;
         if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
         apply(nps, tgt, stall, $urandom);
         check_model($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
